// File: rtl/game_flow_ctrl.sv
// Top-level game-flow FSM: screen mode, lives, level, per-level restarts and motion freeze.
// Define PAUSE_KEY_EN to build the optional PAUSED state driven by pause_key_i.
module game_flow_ctrl #(
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned NUM_LEVELS   = 3,
    parameter int unsigned PAUSE_FRAMES = 60,
    parameter int unsigned END_FRAMES   = 180
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start_of_frame_i,
    input  logic       start_key_i,
    input  logic       pause_key_i,
    input  logic       player_hit_i,
    input  logic       level_cleared_i,
    output logic [1:0] bg_state_o,
    output logic [1:0] lives_left_o,
    output logic [1:0] level_o,
    output logic       level_reset_n_o,
    output logic       freeze_o
);

    localparam int unsigned MaxFrames = (PAUSE_FRAMES > END_FRAMES) ? PAUSE_FRAMES : END_FRAMES;
    localparam int unsigned TimerW    = $clog2(MaxFrames) + 1;

    localparam logic [TimerW-1:0] TimerMax  = {TimerW{1'b1}};
    localparam logic [TimerW-1:0] TimerOne  = TimerW'(1);
    localparam logic [TimerW-1:0] PauseLast = TimerW'(PAUSE_FRAMES - 1);
    localparam logic [TimerW-1:0] EndLast   = TimerW'(END_FRAMES - 1);
    localparam logic [1:0]        LivesInit = 2'(LIVES_INIT);
    localparam logic [1:0]        LastLevel = 2'(NUM_LEVELS - 1);

`ifdef PAUSE_KEY_EN
    typedef enum logic [2:0] {
        StWelcome, StLoad, StPlay, StHitPause, StGameOver, StWin, StPaused
    } state_e;
`else
    typedef enum logic [2:0] {
        StWelcome, StLoad, StPlay, StHitPause, StGameOver, StWin
    } state_e;
`endif

    state_e            state_q, state_d;
    logic [1:0]        lives_q, lives_d;
    logic [1:0]        level_q, level_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [1:0]        bg_q, bg_d;
    logic              lrn_q, lrn_d;
    logic              freeze_q, freeze_d;

    // Keys are asynchronous: two-flop synchroniser, then rising-edge detect.
    logic [1:0] start_sync_q;
    logic       start_prev_q;
    logic       start_edge;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            start_sync_q <= 2'b00;
            start_prev_q <= 1'b0;
        end else begin
            start_sync_q <= {start_sync_q[0], start_key_i};
            start_prev_q <= start_sync_q[1];
        end
    end

    assign start_edge = start_sync_q[1] & ~start_prev_q;

`ifdef PAUSE_KEY_EN
    logic [1:0] pause_sync_q;
    logic       pause_prev_q;
    logic       pause_edge;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pause_sync_q <= 2'b00;
            pause_prev_q <= 1'b0;
        end else begin
            pause_sync_q <= {pause_sync_q[0], pause_key_i};
            pause_prev_q <= pause_sync_q[1];
        end
    end

    assign pause_edge = pause_sync_q[1] & ~pause_prev_q;
`else
    logic unused_pause_key;
    assign unused_pause_key = pause_key_i;
`endif

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        unique case (state_q)
            StWelcome: begin
                if (start_edge) begin
                    lives_d = LivesInit;
                    level_d = 2'd0;
                    state_d = StLoad;
                end
            end
            StLoad: state_d = StPlay;
            StPlay: begin
                // A hit takes priority over every other event in the same cycle.
                if (player_hit_i) begin
                    lives_d = lives_q - 2'd1;
                    state_d = (lives_q == 2'd1) ? StGameOver : StHitPause;
                end
`ifdef PAUSE_KEY_EN
                else if (pause_edge) begin
                    state_d = StPaused;
                end
`endif
                else if (level_cleared_i) begin
                    if (level_q == LastLevel) begin
                        state_d = StWin;
                    end else begin
                        level_d = level_q + 2'd1;
                        state_d = StLoad;
                    end
                end
            end
            StHitPause: begin
                if (start_of_frame_i && (timer_q == PauseLast)) state_d = StLoad;
            end
`ifdef PAUSE_KEY_EN
            StPaused: begin
                if (pause_edge) state_d = StPlay;
            end
`endif
            StGameOver, StWin: begin
                if (start_of_frame_i && (timer_q == EndLast)) state_d = StWelcome;
            end
            default: state_d = StWelcome;
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (start_of_frame_i && (timer_q != TimerMax)) begin
            timer_d = timer_q + TimerOne;
        end
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        bg_d     = 2'b01;
        lrn_d    = 1'b1;
        freeze_d = 1'b1;
        unique case (state_d)
            StWelcome:  bg_d = 2'b00;
            StLoad:     lrn_d = 1'b0;
            StPlay:     freeze_d = 1'b0;
            StGameOver: bg_d = 2'b10;
            StWin:      bg_d = 2'b11;
            default:    bg_d = 2'b01;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= StWelcome;
            lives_q  <= 2'd0;
            level_q  <= 2'd0;
            timer_q  <= '0;
            bg_q     <= 2'b00;
            lrn_q    <= 1'b1;
            freeze_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            lives_q  <= lives_d;
            level_q  <= level_d;
            timer_q  <= timer_d;
            bg_q     <= bg_d;
            lrn_q    <= lrn_d;
            freeze_q <= freeze_d;
        end
    end

    assign bg_state_o      = bg_q;
    assign lives_left_o    = lives_q;
    assign level_o         = level_q;
    assign level_reset_n_o = lrn_q;
    assign freeze_o        = freeze_q;

endmodule
